// File: rtl/traffic_phase_ctrl.sv
// Two-road traffic-light phase controller: 1 s tick, four-phase FSM, per-road phase length/elapsed count.
// Optional night yellow-flash mode is compiled in with `define NIGHT_FLASH_EN.
module traffic_phase_ctrl #(
  parameter logic [25:0] CNT_MAX  = 26'd50_000_000,
  parameter logic [5:0]  GREEN_T  = 6'd15,
  parameter logic [5:0]  YELLOW_T = 6'd3
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
`ifdef NIGHT_FLASH_EN
  input  logic       night,
`endif
  output logic [5:0] cnt1,
  output logic [5:0] x1,
  output logic [5:0] cnt2,
  output logic [5:0] x2,
  output logic [2:0] light1,
  output logic [2:0] light2
);

  localparam logic [5:0] RED_T = GREEN_T + YELLOW_T;
  localparam logic [2:0] L_RED = 3'b100;
  localparam logic [2:0] L_YEL = 3'b010;
  localparam logic [2:0] L_GRN = 3'b001;

  typedef enum logic [2:0] {
    S_G1,
    S_Y1,
    S_G2,
`ifdef NIGHT_FLASH_EN
    S_Y2,
    S_NIGHT
`else
    S_Y2
`endif
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [25:0] r_t1s;
  logic        w_tick;
  logic        w_end1;
  logic        w_end2;
  logic [5:0]  r_cnt1, r_cnt2, r_x1, r_x2;
  logic [5:0]  w_cnt1_nx, w_cnt2_nx, w_x1_nx, w_x2_nx;
  logic        w_t1s_clr;
`ifdef NIGHT_FLASH_EN
  logic        r_flash;
  logic        w_flash_nx;
`endif

  assign w_tick = (r_t1s == CNT_MAX - 26'd1);

`ifdef NIGHT_FLASH_EN
  // Leaving night mode restarts the second timer so the first green second is full length.
  assign w_t1s_clr = (r_state == S_NIGHT) && !night;
`else
  assign w_t1s_clr = 1'b0;
`endif

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)
      r_t1s <= 26'd0;
    else if (w_t1s_clr || w_tick)
      r_t1s <= 26'd0;
    else
      r_t1s <= r_t1s + 26'd1;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)
      r_state <= S_G1;
    else
      r_state <= w_next;
  end

  // A phase ends for both roads at yellow->green changes, since the red road's count wraps there too.
  always_comb begin
    w_next = r_state;
    w_end1 = 1'b0;
    w_end2 = 1'b0;
    case (r_state)
      S_G1: if (w_tick && r_cnt1 == GREEN_T - 6'd1) begin
        w_next = S_Y1;
        w_end1 = 1'b1;
      end
      S_Y1: if (w_tick && r_cnt1 == YELLOW_T - 6'd1) begin
        w_next = S_G2;
        w_end1 = 1'b1;
        w_end2 = 1'b1;
      end
      S_G2: if (w_tick && r_cnt2 == GREEN_T - 6'd1) begin
        w_next = S_Y2;
        w_end2 = 1'b1;
      end
      S_Y2: if (w_tick && r_cnt2 == YELLOW_T - 6'd1) begin
        w_next = S_G1;
        w_end1 = 1'b1;
        w_end2 = 1'b1;
      end
`ifdef NIGHT_FLASH_EN
      S_NIGHT: if (!night) w_next = S_G1;
`endif
      default: w_next = S_G1;
    endcase
`ifdef NIGHT_FLASH_EN
    if (night) w_next = S_NIGHT;
`endif
  end

  always_comb begin
    w_cnt1_nx = r_cnt1;
    w_cnt2_nx = r_cnt2;
    if (w_tick) begin
      w_cnt1_nx = w_end1 ? 6'd0 : r_cnt1 + 6'd1;
      w_cnt2_nx = w_end2 ? 6'd0 : r_cnt2 + 6'd1;
    end
`ifdef NIGHT_FLASH_EN
    if (r_state == S_NIGHT || w_next == S_NIGHT) begin
      w_cnt1_nx = 6'd0;
      w_cnt2_nx = 6'd0;
    end
`endif
    w_x1_nx = GREEN_T;
    w_x2_nx = RED_T;
    case (w_next)
      S_G1: begin w_x1_nx = GREEN_T;  w_x2_nx = RED_T;    end
      S_Y1: begin w_x1_nx = YELLOW_T; w_x2_nx = RED_T;    end
      S_G2: begin w_x1_nx = RED_T;    w_x2_nx = GREEN_T;  end
      S_Y2: begin w_x1_nx = RED_T;    w_x2_nx = YELLOW_T; end
`ifdef NIGHT_FLASH_EN
      S_NIGHT: begin w_x1_nx = 6'd0;  w_x2_nx = 6'd0;     end
`endif
      default: begin w_x1_nx = GREEN_T; w_x2_nx = RED_T;  end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_cnt1 <= 6'd0;
      r_cnt2 <= 6'd0;
      r_x1   <= GREEN_T;
      r_x2   <= RED_T;
    end else begin
      r_cnt1 <= w_cnt1_nx;
      r_cnt2 <= w_cnt2_nx;
      r_x1   <= w_x1_nx;
      r_x2   <= w_x2_nx;
    end
  end

`ifdef NIGHT_FLASH_EN
  // Flash phase starts "on" when night mode is entered and flips on every tick while in it.
  always_comb begin
    w_flash_nx = 1'b1;
    if (r_state == S_NIGHT && w_next == S_NIGHT && w_tick)
      w_flash_nx = ~r_flash;
    else if (r_state == S_NIGHT && w_next == S_NIGHT)
      w_flash_nx = r_flash;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)
      r_flash <= 1'b1;
    else
      r_flash <= w_flash_nx;
  end
`endif

  always_comb begin
    light1 = L_GRN;
    light2 = L_RED;
    case (r_state)
      S_G1: begin light1 = L_GRN; light2 = L_RED; end
      S_Y1: begin light1 = L_YEL; light2 = L_RED; end
      S_G2: begin light1 = L_RED; light2 = L_GRN; end
      S_Y2: begin light1 = L_RED; light2 = L_YEL; end
`ifdef NIGHT_FLASH_EN
      S_NIGHT: begin
        light1 = r_flash ? L_YEL : 3'b000;
        light2 = r_flash ? L_YEL : 3'b000;
      end
`endif
      default: begin light1 = L_GRN; light2 = L_RED; end
    endcase
  end

  assign cnt1 = r_cnt1;
  assign cnt2 = r_cnt2;
  assign x1   = r_x1;
  assign x2   = r_x2;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Self-checking bench for traffic_phase_ctrl: vector table, async-reset sequence, randomized resets vs. a
// tick-count reference model; night-flash sequence when NIGHT_FLASH_EN is defined.
module tb_traffic_phase_ctrl;
  localparam int CNT = 10;
  localparam int G   = 5;
  localparam int Y   = 2;
  localparam int P   = G + Y;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
`ifdef NIGHT_FLASH_EN
  logic       night = 1'b0;
`endif
  logic [5:0] cnt1, x1, cnt2, x2;
  logic [2:0] light1, light2;

  int n_run  = 0;
  int n_fail = 0;
  int edges  = 0;
  bit inv_en = 1'b1;

  traffic_phase_ctrl #(.CNT_MAX(26'd10), .GREEN_T(6'd5), .YELLOW_T(6'd2)) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
`ifdef NIGHT_FLASH_EN
    .night    (night),
`endif
    .cnt1     (cnt1),
    .x1       (x1),
    .cnt2     (cnt2),
    .x2       (x2),
    .light1   (light1),
    .light2   (light2)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    int         k;
    logic [5:0] x1, c1, x2, c2;
    logic [2:0] l1, l2;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %0d expected %0d", nm, edges, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [5:0] ex1, input logic [5:0] ec1,
                         input logic [5:0] ex2, input logic [5:0] ec2,
                         input logic [2:0] el1, input logic [2:0] el2);
    chk({tag, ".x1"}, x1, ex1);
    chk({tag, ".cnt1"}, cnt1, ec1);
    chk({tag, ".x2"}, x2, ex2);
    chk({tag, ".cnt2"}, cnt2, ec2);
    chk({tag, ".light1"}, light1, el1);
    chk({tag, ".light2"}, light2, el2);
  endtask

  // Reference: whole seconds since release, folded into one 2*(G+Y) second cycle.
  task automatic model(input int k, output logic [5:0] ex1, output logic [5:0] ec1,
                       output logic [5:0] ex2, output logic [5:0] ec2,
                       output logic [2:0] el1, output logic [2:0] el2);
    int s;
    s = (k / CNT) % (2 * P);
    if (s < G) begin
      ex1 = G; ec1 = s;     el1 = 3'b001; ex2 = P; ec2 = s;         el2 = 3'b100;
    end else if (s < P) begin
      ex1 = Y; ec1 = s - G; el1 = 3'b010; ex2 = P; ec2 = s;         el2 = 3'b100;
    end else if (s < P + G) begin
      ex1 = P; ec1 = s - P; el1 = 3'b100; ex2 = G; ec2 = s - P;     el2 = 3'b001;
    end else begin
      ex1 = P; ec1 = s - P; el1 = 3'b100; ex2 = Y; ec2 = s - P - G; el2 = 3'b010;
    end
  endtask

  task automatic chk_model(input string tag);
    logic [5:0] a, b, c, d;
    logic [2:0] e, f;
    model(edges, a, b, c, d, e, f);
    chk_all(tag, a, b, c, d, e, f);
  endtask

  task automatic adv();
    @(posedge sys_clk);
    edges++;
    #2;
  endtask

  task automatic run(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      adv();
      chk_model(tag);
    end
  endtask

  task automatic release_rst();
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    edges = 0;
    #1;
    chk_model("release");
  endtask

  always @(negedge sys_clk) begin
    if (sys_rst_n && inv_en) begin
      n_run++;
      if (!(cnt1 < x1 && cnt2 < x2)) begin
        n_fail++;
        $display("FAIL invariant: cnt1=%0d x1=%0d cnt2=%0d x2=%0d", cnt1, x1, cnt2, x2);
      end
    end
  end

  initial begin
    vec_t tbl[7];
    int   hold;
    bit   seen;
    tbl[0] = '{0,   6'd5, 6'd0, 6'd7, 6'd0, 3'b001, 3'b100};
    tbl[1] = '{9,   6'd5, 6'd0, 6'd7, 6'd0, 3'b001, 3'b100};
    tbl[2] = '{10,  6'd5, 6'd1, 6'd7, 6'd1, 3'b001, 3'b100};
    tbl[3] = '{50,  6'd2, 6'd0, 6'd7, 6'd5, 3'b010, 3'b100};
    tbl[4] = '{70,  6'd7, 6'd0, 6'd5, 6'd0, 3'b100, 3'b001};
    tbl[5] = '{120, 6'd7, 6'd5, 6'd2, 6'd0, 3'b100, 3'b010};
    tbl[6] = '{140, 6'd5, 6'd0, 6'd7, 6'd0, 3'b001, 3'b100};

    repeat (3) @(negedge sys_clk);
    chk_all("in_reset", 6'd5, 6'd0, 6'd7, 6'd0, 3'b001, 3'b100);
    release_rst();

    for (int i = 0; i < 7; i++) begin
      while (edges < tbl[i].k) adv();
      chk_all($sformatf("vec%0d", i), tbl[i].x1, tbl[i].c1, tbl[i].x2, tbl[i].c2, tbl[i].l1, tbl[i].l2);
    end

    // Into S_Y2 with cnt2=1, then assert reset between edges and look before any edge arrives.
    run(135, "to_y2");
    chk("pre_rst.light2", light2, 3'b010);
    chk("pre_rst.cnt2", cnt2, 6'd1);
    #3 sys_rst_n = 1'b0;
    #1 chk_all("async_rst", 6'd5, 6'd0, 6'd7, 6'd0, 3'b001, 3'b100);
    repeat (2) @(negedge sys_clk);
    release_rst();
    run(25, "post_rst");

    for (int r = 0; r < 8; r++) begin
      run($urandom_range(1, 300), "rand");
      #($urandom_range(1, 6)) sys_rst_n = 1'b0;
      #1 chk_all("rand_rst", 6'd5, 6'd0, 6'd7, 6'd0, 3'b001, 3'b100);
      hold = $urandom_range(1, 3);
      repeat (hold) @(negedge sys_clk);
      release_rst();
    end

`ifdef NIGHT_FLASH_EN
    run(75, "to_g2");
    chk("pre_night.light2", light2, 3'b001);
    inv_en = 1'b0;
    night = 1'b1;
    adv();
    chk_all("night_on", 6'd0, 6'd0, 6'd0, 6'd0, 3'b010, 3'b010);
    seen = 1'b0;
    for (int i = 0; i <= CNT && !seen; i++) begin
      adv();
      if (light1 === 3'b000) seen = 1'b1;
    end
    chk("night_off_seen", {31'd0, seen}, 32'd1);
    chk_all("night_dark", 6'd0, 6'd0, 6'd0, 6'd0, 3'b000, 3'b000);
    repeat (CNT) adv();
    chk_all("night_relit", 6'd0, 6'd0, 6'd0, 6'd0, 3'b010, 3'b010);
    night = 1'b0;
    adv();
    edges = 0;
    chk_all("night_exit", 6'd5, 6'd0, 6'd7, 6'd0, 3'b001, 3'b100);
    inv_en = 1'b1;
    run(25, "after_night");
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/traffic_phase_ctrl.md
Name: traffic_phase_ctrl

Overview:
- Two-road traffic-light phase controller.
- Generates the per-road phase length (x1/x2) and elapsed-seconds count (cnt1/cnt2) consumed by the downstream 4-digit countdown display, which shows x-cnt per road as a 2-digit value (tens digit 0 or 1 only, so the displayed value is at most 19). Also drives the red/yellow/green lamps.
- Four-state phase FSM advanced by an internal 1 s tick.

Parameters:
- CNT_MAX, 26'd50_000_000, sys_clk cycles per 1 s tick.
- GREEN_T, 6'd15, green duration in seconds (1..18).
- YELLOW_T, 6'd3, yellow duration in seconds (1..18); GREEN_T+YELLOW_T must be <= 19.

Ports:
- sys_clk  input  1  system clock, 50 MHz.
- sys_rst_n  input  1  reset, asynchronous, active-low.
- cnt1  output  6  road-1 elapsed seconds in current phase.
- x1  output  6  road-1 current phase length in seconds.
- cnt2  output  6  road-2 elapsed seconds in current phase.
- x2  output  6  road-2 current phase length in seconds.
- light1  output  3  road-1 lamps {red,yellow,green}, active-high.
- light2  output  3  road-2 lamps {red,yellow,green}, active-high.

Behaviour:
- Tick: 26-bit counter t1s counts 0..CNT_MAX-1 and wraps. tick=1 for one cycle when t1s==CNT_MAX-1.
- FSM states: S_G1 (road1 green, road2 red); S_Y1 (road1 yellow, road2 red); S_G2 (road1 red, road2 green); S_Y2 (road1 red, road2 yellow).
- Transitions occur only on tick, and only at phase end:
  - S_G1->S_Y1 when cnt1==GREEN_T-1.
  - S_Y1->S_G2 when cnt1==YELLOW_T-1.
  - S_G2->S_Y2 when cnt2==GREEN_T-1.
  - S_Y2->S_G1 when cnt2==YELLOW_T-1.
- Phase lengths, registered and updated in the same cycle as the state change:
  - Green road: x=GREEN_T. Yellow road: x=YELLOW_T.
  - Red road: x=GREEN_T+YELLOW_T, held constant across both of the other road's phases.
- Counters:
  - On tick, the counter of each road whose phase does not end increments by 1.
  - A road whose phase ends on this tick loads 0.
  - The red road's counter runs 0..GREEN_T+YELLOW_T-1 continuously. It is not cleared at the other road's green->yellow change.
- Both roads change on the same tick at S_Y1->S_G2 and S_Y2->S_G1. The red road's count reaches x-1 exactly when the yellow road's does, so both counters load 0 together.
- Invariant: cnt < x at all times. x-cnt runs x..1 and never reaches 0 outside reset.
- Lamps are decoded from registered state: exactly one lamp is lit per road. Lamps and x/cnt change in the same cycle, the one after the tick.
- Reset values:
  - state=S_G1, t1s=0.
  - cnt1=0, x1=GREEN_T; cnt2=0, x2=GREEN_T+YELLOW_T.
  - light1=3'b001, light2=3'b100.
- Reset mid-operation: all of the above restored asynchronously. The first tick after release comes CNT_MAX cycles later.
- Full cycle period: 2*(GREEN_T+YELLOW_T) ticks.

Optional Feature:
- Macro: NIGHT_FLASH_EN.
- Defined: adds input port night  input  1  (after sys_rst_n), sampled on sys_clk.
  - While night=1: FSM held in S_NIGHT. Both roads show yellow only, toggling on every tick (1 s on / 1 s off, starting on). x1=x2=cnt1=cnt2=0. Tick counter keeps running.
  - On night falling: next cycle enters S_G1 with reset values for cnt/x/lamps, and t1s cleared to 0.
- Not defined: no night port, no S_NIGHT state. Behaviour is exactly as above.

Test Plan (sim with CNT_MAX=10, GREEN_T=5, YELLOW_T=2):
- Reset release:
  - After release: x1=5, cnt1=0, x2=7, cnt2=0, light1=001, light2=100.
  - First increment to cnt1=1, cnt2=1 occurs 10 cycles after release.
- Green->yellow: after 5 ticks, x1=2, cnt1=0, light1=010. Road 2 unchanged (x2=7, cnt2=5, red).
- Simultaneous change: after 7 ticks, state=S_G2, x1=7, cnt1=0, light1=100; x2=5, cnt2=0, light2=001.
- Full wrap: after 14 ticks, state and all outputs equal the post-reset values. Over the whole run, cnt<x holds on every cycle.
- Async reset asserted mid S_Y2 (cnt2=1): outputs return to reset values immediately, without waiting for a clock edge.
- NIGHT_FLASH_EN:
  - Raising night in S_G2: next cycle light1=light2=010, all x/cnt=0. Lamps toggle to 000 after 1 tick, then back to 010.
  - Dropping night: next cycle S_G1 reset values.
